// File: rtl/node_port_sequencer.sv
// node_port_sequencer
// Execution sequencer for one TIS node. It sits between the instruction
// ROM/PC block and the four neighbour ports. It issues step_en, which is the
// ROM/PC clock enable and the ACC write qualifier. step_en is held low while
// a MOV-style instruction waits on a port read or write handshake.
//
// Build option: define TIS_ANY_LAST_EN to widen src_port/dst_port to 3 bits.
// This adds the ANY (4) and LAST (5) pseudo-ports and a last_port register.
// The default build uses 2-bit port fields and has neither.
module node_port_sequencer #(
    parameter int DATA_W = 11,
    parameter int NPORTS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     src_is_port,
`ifdef TIS_ANY_LAST_EN
    input  logic [2:0]               src_port,
`else
    input  logic [1:0]               src_port,
`endif
    input  logic                     dst_is_port,
`ifdef TIS_ANY_LAST_EN
    input  logic [2:0]               dst_port,
`else
    input  logic [1:0]               dst_port,
`endif
    input  logic [DATA_W-1:0]        operand_in,
    input  logic [NPORTS-1:0]        in_valid,
    input  logic [NPORTS*DATA_W-1:0] in_data,
    output logic [NPORTS-1:0]        in_ready,
    output logic [NPORTS-1:0]        out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic [NPORTS-1:0]        out_ready,
    output logic [DATA_W-1:0]        operand,
    output logic                     step_en,
    output logic                     stall
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        RD_WAIT = 3'd2,
        WR_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Resolved port selects. *_sel is the one-hot set of ports that take part
    // in the handshake. *_nil means the transfer completes with no handshake.
    logic [NPORTS-1:0] rd_sel, wr_sel;
    logic              rd_nil, wr_nil;
    logic              rd_done, wr_done;
    logic [1:0]        rd_idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] src_value;

    // Returns a one-hot vector with only the lowest set bit of v.
    // This gives LEFT, RIGHT, UP, DOWN priority.
    function automatic logic [NPORTS-1:0] lowest_onehot(input logic [NPORTS-1:0] v);
        lowest_onehot = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (v[k]) begin
                lowest_onehot    = '0;
                lowest_onehot[k] = 1'b1;
            end
        end
    endfunction

    // Returns the index of the lowest set bit of v, or 0 when v is empty.
    function automatic logic [1:0] lowest_idx(input logic [NPORTS-1:0] v);
        lowest_idx = 2'd0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (v[k]) lowest_idx = 2'(k);
        end
    endfunction

`ifdef TIS_ANY_LAST_EN
    localparam logic [2:0] PORT_ANY  = 3'd4;
    localparam logic [2:0] PORT_LAST = 3'd5;
    localparam logic [2:0] LAST_NONE = 3'd7;

    // last_port holds the port used by the most recent ANY transfer.
    // LAST_NONE (bit 2 set) means no ANY transfer has happened yet.
    logic [2:0] last_port_q, last_port_d;
    logic [1:0] wr_idx;

    // Resolves direct, ANY and LAST codes to handshake selects.
    always_comb begin
        rd_sel = '0;
        rd_nil = 1'b0;
        wr_sel = '0;
        wr_nil = 1'b0;
        case (src_port)
            3'd0, 3'd1, 3'd2, 3'd3: rd_sel[src_port[1:0]] = 1'b1;
            PORT_ANY:               rd_sel = lowest_onehot(in_valid);
            PORT_LAST: begin
                if (last_port_q[2]) rd_nil = 1'b1;
                else                rd_sel[last_port_q[1:0]] = 1'b1;
            end
            default:                rd_nil = 1'b1;
        endcase
        case (dst_port)
            3'd0, 3'd1, 3'd2, 3'd3: wr_sel[dst_port[1:0]] = 1'b1;
            PORT_ANY:               wr_sel = '1;
            PORT_LAST: begin
                if (last_port_q[2]) wr_nil = 1'b1;
                else                wr_sel[last_port_q[1:0]] = 1'b1;
            end
            default:                wr_nil = 1'b1;
        endcase
    end

    // wr_idx is the first accepting port by priority; an ANY write records it.
    assign wr_idx = lowest_idx(wr_sel & out_ready);
`else
    // Decodes the 2-bit port fields directly to one-hot selects.
    always_comb begin
        rd_sel           = '0;
        wr_sel           = '0;
        rd_sel[src_port] = 1'b1;
        wr_sel[dst_port] = 1'b1;
    end

    assign rd_nil = 1'b0;
    assign wr_nil = 1'b0;
`endif

    assign rd_idx  = lowest_idx(rd_sel);
    assign rd_word = in_data[int'(rd_idx) * DATA_W +: DATA_W];
    assign rd_done = rd_nil || (|(rd_sel & in_valid));
    assign wr_done = wr_nil || (|(wr_sel & out_ready));

    // A port source always takes the value captured by the completed read.
    assign src_value = src_is_port ? rd_data_q : operand_in;
    assign operand   = src_value;
    assign out_data  = (state_q == WR_WAIT) ? src_value : '0;
    assign stall     = (state_q == RD_WAIT) || (state_q == WR_WAIT);

    // Next-state, handshake and step-enable decode for the sequencer FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        rd_data_d = rd_data_q;
`ifdef TIS_ANY_LAST_EN
        last_port_d = last_port_q;
`endif
        in_ready  = '0;
        out_valid = '0;
        step_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) state_d = EXEC;
            end

            EXEC: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (src_is_port) begin
                    state_d = RD_WAIT;
                end else if (dst_is_port) begin
                    state_d = WR_WAIT;
                end else begin
                    // A register or immediate instruction retires in this cycle.
                    step_en = 1'b1;
                end
            end

            RD_WAIT: begin
                in_ready = rd_sel;
                if (rd_done) begin
                    rd_data_d = rd_nil ? '0 : rd_word;
`ifdef TIS_ANY_LAST_EN
                    if (src_port == PORT_ANY) last_port_d = {1'b0, rd_idx};
`endif
                    // For a port-to-port MOV, the write runs after the read.
                    state_d = dst_is_port ? WR_WAIT : DONE;
                end
            end

            DONE: begin
                step_en = 1'b1;
                state_d = EXEC;
            end

            WR_WAIT: begin
                // out_valid is held until the neighbour accepts.
                out_valid = wr_sel;
                if (wr_done) begin
                    step_en = 1'b1;
`ifdef TIS_ANY_LAST_EN
                    if (dst_port == PORT_ANY) last_port_d = {1'b0, wr_idx};
`endif
                    state_d = EXEC;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State registers, with a synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. All flops then
        // update together at the edge, whatever order the statements are in.
        if (reset) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
`ifdef TIS_ANY_LAST_EN
            last_port_q <= LAST_NONE;
`endif
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
`ifdef TIS_ANY_LAST_EN
            last_port_q <= last_port_d;
`endif
        end
    end

endmodule

// File: tb/tb_node_port_sequencer.sv
// tb_node_port_sequencer
// Directed bench for node_port_sequencer. Inputs change 1 ns after the rising
// edge. Outputs are compared a little later in the same cycle.
module tb_node_port_sequencer;

    localparam int DATA_W = 11;
    localparam int NPORTS = 4;
`ifdef TIS_ANY_LAST_EN
    localparam int PW = 3;
`else
    localparam int PW = 2;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     run;
    logic                     src_is_port;
    logic [PW-1:0]            src_port;
    logic                     dst_is_port;
    logic [PW-1:0]            dst_port;
    logic [DATA_W-1:0]        operand_in;
    logic [NPORTS-1:0]        in_valid;
    logic [NPORTS*DATA_W-1:0] in_data;
    logic [NPORTS-1:0]        in_ready;
    logic [NPORTS-1:0]        out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [NPORTS-1:0]        out_ready;
    logic [DATA_W-1:0]        operand;
    logic                     step_en;
    logic                     stall;

    int n_assert = 0;
    int n_fail   = 0;

    node_port_sequencer #(.DATA_W(DATA_W), .NPORTS(NPORTS)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .src_is_port (src_is_port),
        .src_port    (src_port),
        .dst_is_port (dst_is_port),
        .dst_port    (dst_port),
        .operand_in  (operand_in),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .operand     (operand),
        .step_en     (step_en),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port_data(input int k, input logic [DATA_W-1:0] v);
        in_data[k*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        src_is_port = 1'b0;
        src_port    = '0;
        dst_is_port = 1'b0;
        dst_port    = '0;
        operand_in  = '0;
        in_valid    = '0;
        in_data     = '0;
        out_ready   = '0;

        // Reset held for two cycles.
        clk_step();
        clk_step();
        #1;
        check("rst_step_en", step_en, 0);
        check("rst_stall", stall, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_operand", operand, 0);

        // Release reset and start running. The first cycle is still IDLE.
        reset = 1'b0;
        run   = 1'b1;
        #1;
        check("idle_step_en", step_en, 0);
        clk_step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("nonport_step_en", step_en, 1);
            check("nonport_in_ready", in_ready, 0);
            check("nonport_out_valid", out_valid, 0);
            clk_step();
        end

        // Read from UP. Data -7 arrives after 4 wait cycles.
        src_is_port = 1'b1;
        src_port    = PW'(2);
        #1;
        check("rd_exec_step_en", step_en, 0);
        clk_step();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rd_wait_in_ready", in_ready, 4'b0100);
            check("rd_wait_step_en", step_en, 0);
            check("rd_wait_stall", stall, 1);
            clk_step();
        end
        in_valid = 4'b0100;
        set_port_data(2, 11'h7F9);
        #1;
        check("rd_xfer_in_ready", in_ready, 4'b0100);
        check("rd_xfer_step_en", step_en, 0);
        clk_step();
        in_valid = '0;
        #1;
        check("rd_done_step_en", step_en, 1);
        check("rd_done_operand", operand, 11'h7F9);
        check("rd_done_stall", stall, 0);
        check("rd_done_in_ready", in_ready, 0);
        clk_step();

        // Write 300 to RIGHT. The neighbour becomes ready after 3 cycles.
        src_is_port = 1'b0;
        dst_is_port = 1'b1;
        dst_port    = PW'(1);
        operand_in  = 11'd300;
        #1;
        check("wr_exec_step_en", step_en, 0);
        clk_step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wr_wait_out_valid", out_valid, 4'b0010);
            check("wr_wait_out_data", out_data, 300);
            check("wr_wait_step_en", step_en, 0);
            check("wr_wait_stall", stall, 1);
            clk_step();
        end
        out_ready = 4'b0010;
        #1;
        check("wr_hs_out_valid", out_valid, 4'b0010);
        check("wr_hs_step_en", step_en, 1);
        clk_step();
        out_ready   = '0;
        dst_is_port = 1'b0;
        #1;
        check("wr_after_out_valid", out_valid, 0);
        check("wr_after_step_en", step_en, 1);
        clk_step();

        // Port to port: LEFT to DOWN, data 1023. The neighbour is ready at once.
        src_is_port = 1'b1;
        src_port    = PW'(0);
        dst_is_port = 1'b1;
        dst_port    = PW'(3);
        in_valid    = 4'b0001;
        set_port_data(0, 11'd1023);
        clk_step();
        #1;
        check("p2p_rd_in_ready", in_ready, 4'b0001);
        check("p2p_rd_out_valid", out_valid, 0);
        check("p2p_rd_step_en", step_en, 0);
        clk_step();
        in_valid = '0;
        #1;
        check("p2p_wr_out_valid", out_valid, 4'b1000);
        check("p2p_wr_out_data", out_data, 1023);
        check("p2p_wr_step_en_wait", step_en, 0);
        out_ready = 4'b1000;
        #1;
        check("p2p_wr_step_en", step_en, 1);
        check("p2p_operand", operand, 1023);
        clk_step();
        out_ready = '0;

        // Same port read then write (RIGHT to RIGHT). The read finishes first.
        src_port = PW'(1);
        dst_port = PW'(1);
        in_valid = 4'b0010;
        set_port_data(1, 11'd42);
        clk_step();
        #1;
        check("same_rd_in_ready", in_ready, 4'b0010);
        check("same_rd_out_valid", out_valid, 0);
        clk_step();
        in_valid  = '0;
        out_ready = 4'b0010;
        #1;
        check("same_wr_out_valid", out_valid, 4'b0010);
        check("same_wr_out_data", out_data, 42);
        check("same_wr_step_en", step_en, 1);
        clk_step();
        out_ready   = '0;
        src_is_port = 1'b0;

        // run drops during WR_WAIT. The write still completes, then the FSM goes IDLE.
        dst_is_port = 1'b1;
        dst_port    = PW'(0);
        operand_in  = 11'd5;
        clk_step();
        run = 1'b0;
        #1;
        check("runoff_wr_out_valid", out_valid, 4'b0001);
        check("runoff_wr_stall", stall, 1);
        clk_step();
        #1;
        check("runoff_wr_hold_valid", out_valid, 4'b0001);
        out_ready = 4'b0001;
        #1;
        check("runoff_wr_step_en", step_en, 1);
        clk_step();
        out_ready   = '0;
        dst_is_port = 1'b0;
        #1;
        check("runoff_exec_step_en", step_en, 0);
        clk_step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("runoff_idle_step_en", step_en, 0);
            clk_step();
        end
        run = 1'b1;
        #1;
        check("rerun_idle_step_en", step_en, 0);
        clk_step();
        #1;
        check("rerun_exec_step_en", step_en, 1);

        // A reset during a read handshake abandons the read.
        src_is_port = 1'b1;
        src_port    = PW'(3);
        clk_step();
        #1;
        check("abort_rd_in_ready", in_ready, 4'b1000);
        reset = 1'b1;
        clk_step();
        #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_stall", stall, 0);
        check("abort_step_en", step_en, 0);
        reset       = 1'b0;
        src_is_port = 1'b0;

`ifdef TIS_ANY_LAST_EN
        // LAST read right after reset. It returns 0 with no handshake.
        src_is_port = 1'b1;
        src_port    = 3'd5;
        in_valid    = 4'b1111;
        set_port_data(0, 11'd100);
        set_port_data(1, 11'd101);
        set_port_data(2, 11'd102);
        set_port_data(3, 11'd103);
        clk_step();
        #1;
        check("last_none_exec_step_en", step_en, 0);
        clk_step();
        #1;
        check("last_none_in_ready", in_ready, 0);
        clk_step();
        #1;
        check("last_none_done_step_en", step_en, 1);
        check("last_none_operand", operand, 0);
        check("last_none_done_in_ready", in_ready, 0);
        clk_step();

        // ANY read with in_valid=1010. RIGHT wins.
        src_port = 3'd4;
        in_valid = 4'b1010;
        set_port_data(1, 11'd11);
        set_port_data(3, 11'd22);
        clk_step();
        #1;
        check("any_rd_in_ready", in_ready, 4'b0010);
        clk_step();
        in_valid = '0;
        #1;
        check("any_rd_operand", operand, 11);
        clk_step();

        // LAST write goes to RIGHT, the port used by the ANY read.
        src_is_port = 1'b0;
        dst_is_port = 1'b1;
        dst_port    = 3'd5;
        operand_in  = 11'd77;
        clk_step();
        #1;
        check("last_wr_out_valid", out_valid, 4'b0010);
        check("last_wr_out_data", out_data, 77);
        out_ready = 4'b0010;
        #1;
        check("last_wr_step_en", step_en, 1);
        clk_step();
        out_ready = '0;

        // ANY write. All ports are offered and UP wins over DOWN.
        dst_port   = 3'd4;
        operand_in = 11'd9;
        clk_step();
        #1;
        check("any_wr_out_valid", out_valid, 4'b1111);
        out_ready = 4'b1100;
        #1;
        check("any_wr_step_en", step_en, 1);
        clk_step();
        out_ready = '0;
        dst_port  = 3'd5;
        #1;
        check("any_wr_drop_valid", out_valid, 0);
        clk_step();
        #1;
        check("last_after_any_wr_out_valid", out_valid, 4'b0100);
        out_ready = 4'b0100;
        #1;
        check("last_after_any_wr_step_en", step_en, 1);
        clk_step();
        out_ready   = '0;
        dst_is_port = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/node_port_sequencer.md
Name: node_port_sequencer

Overview:
- Execution sequencer for one TIS node. Sits between the instruction ROM/PC block and the node's four neighbour ports.
- Issues the per-instruction step enable, which drives the ROM/PC clock enable and the ACC write qualifier.
- Stalls that enable while a MOV-style instruction blocks on a port read or write handshake.
- Plain register/immediate instructions retire at 1 per cycle; port traffic uses valid/ready per direction.

Parameters:
DATA_W, 11, signed data word width (matches ACC/jmp_off width)
NPORTS, 4, neighbour ports; index 0=LEFT 1=RIGHT 2=UP 3=DOWN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  global node enable; sampled at instruction boundaries only
src_is_port  in  1  current instruction reads a neighbour port
src_port  in  2  source port index (3 bits when TIS_ANY_LAST_EN)
dst_is_port  in  1  current instruction writes a neighbour port
dst_port  in  2  destination port index (3 bits when TIS_ANY_LAST_EN)
operand_in  in  DATA_W  non-port source value (ACC/immediate/NIL=0)
in_valid  in  NPORTS  neighbour has data for us
in_data  in  NPORTS*DATA_W  packed, port k at [k*DATA_W +: DATA_W]
in_ready  out  NPORTS  we accept in_data[k]
out_valid  out  NPORTS  we offer out_data to port k
out_data  out  DATA_W  shared write data
out_ready  in  NPORTS  neighbour accepts
operand  out  DATA_W  resolved source value for ALU/ACC
step_en  out  1  retire current instruction; wired to ROM clk_en
stall  out  1  high in RD_WAIT/WR_WAIT

Behaviour:
- Reset: state=IDLE, rd_data=0; all outputs 0. Reset mid-handshake abandons the transfer (no valid held).
- States: IDLE, EXEC, RD_WAIT, WR_WAIT, DONE.
- IDLE: if run -> EXEC.
- EXEC (instruction inputs stable): if !run -> IDLE, step_en=0.
  - Neither src nor dst is a port: step_en=1 this cycle, stay EXEC (1 instr/cycle).
  - src_is_port: -> RD_WAIT.
  - dst_is_port only: -> WR_WAIT.
- RD_WAIT: in_ready[src_port]=1, all other in_ready=0. When in_valid[src_port]: rd_data<=in_data[src_port]; then -> WR_WAIT if dst_is_port, else -> DONE.
- DONE: step_en=1; operand=rd_data; -> EXEC.
- WR_WAIT:
  - out_valid[dst_port]=1.
  - out_data = rd_data if src_is_port, else operand_in.
  - When out_ready[dst_port]: step_en=1 this cycle -> EXEC.
  - out_valid must not drop before the handshake.
- operand = rd_data when src_is_port, else operand_in (combinational).
- Minimum latencies: non-port 1 cycle; read 3 (EXEC, RD_WAIT, DONE); write 2; port-to-port 3.
- run deasserted during RD_WAIT/WR_WAIT: the wait continues to completion; run is next checked in EXEC.
- Infinite stall is legal: no timeout; stall stays 1.
- Read and write to the same port index in one instruction: sequential (read completes first), no deadlock inside this block.
- step_en is never high in RD_WAIT or IDLE.

Optional Feature:
- Macro: TIS_ANY_LAST_EN.
- When defined:
  - src_port/dst_port are 3 bits; 4=ANY, 5=LAST.
  - ANY read: in_ready[k]=1 only for the lowest-index k with in_valid[k] (priority LEFT,RIGHT,UP,DOWN).
  - ANY write: out_valid asserted on all four ports; the first out_ready (same priority) completes it; all out_valid drop next cycle.
  - A 3-bit last_port register (reset 7=none) captures the port used by each ANY transfer.
  - LAST resolves to last_port. If none: a read returns 0 in DONE without a handshake, and a write retires immediately as NIL.
- When undefined: 2-bit port fields, no last_port register, codes 4/5 unrepresentable.

Test Plan:
- Reset held 2 cycles, then run=1, no port ops for 5 cycles -> step_en=1 each cycle from the first EXEC cycle; all valid/ready 0.
- src=UP, in_valid[2] raised 4 cycles late with data -7 -> in_ready=4'b0100 throughout; step_en pulses once, 1 cycle after transfer; operand=-7 (11'h7F9).
- dst=RIGHT, operand_in=300, out_ready[1] high after 3 cycles -> out_valid=4'b0010 stable until the handshake; step_en in the handshake cycle; out_data=300.
- Port-to-port LEFT->DOWN, data 1023 -> read completes, then out_valid[3] with 1023, then one step_en.
- run dropped during WR_WAIT -> write still completes with step_en=1, then IDLE; no further steps until run=1.
- TIS_ANY_LAST_EN: ANY read with in_valid=4'b1010 -> in_ready=4'b0010. Then LAST write -> out_valid=4'b0010. LAST read right after reset -> operand 0, no in_ready.
